// File: rtl/vector_fus_wb_arbiter.sv
// Lane write-back stage: per-FU result FIFOs, a round-robin arbiter and a
// registered output slot that drives one VRF write port with req/gnt.
// A done pulse is raised per instruction ID once its last element is granted.
module vector_fus_wb_arbiter #(
  parameter int unsigned NrFUs     = 2,
  parameter int unsigned BufDepth  = 2,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned NrVInsn   = 8,
  localparam int unsigned IdWidth  = $clog2(NrVInsn),
  localparam int unsigned SrcWidth = $clog2(NrFUs),
  localparam int unsigned BeWidth  = DataWidth / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NrFUs-1:0]               fu_valid_i,
  output logic [NrFUs-1:0]               fu_ready_o,
  input  logic [NrFUs*IdWidth-1:0]       fu_id_i,
  input  logic [NrFUs*AddrWidth-1:0]     fu_addr_i,
  input  logic [NrFUs*DataWidth-1:0]     fu_wdata_i,
  input  logic [NrFUs*BeWidth-1:0]       fu_be_i,
  input  logic [NrFUs-1:0]               fu_last_i,
  output logic                           wb_req_o,
  output logic [IdWidth-1:0]             wb_id_o,
  output logic [AddrWidth-1:0]           wb_addr_o,
  output logic [DataWidth-1:0]           wb_wdata_o,
  output logic [BeWidth-1:0]             wb_be_o,
  output logic [SrcWidth-1:0]            wb_src_o,
  input  logic                           wb_gnt_i,
  output logic [NrVInsn-1:0]             vinsn_done_o,
  output logic                           busy_o
);

  localparam int unsigned PtrWidth = $clog2(BufDepth);

  typedef logic [PtrWidth:0] cnt_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [BeWidth-1:0]   be;
    logic                 last;
  } entry_t;

  entry_t              in_entry   [NrFUs];
  entry_t              fifo_mem_q [NrFUs][BufDepth];
  logic [PtrWidth-1:0] wptr_q     [NrFUs];
  logic [PtrWidth-1:0] rptr_q     [NrFUs];
  cnt_t                cnt_q      [NrFUs];

  logic [NrFUs-1:0]    nonempty;
  logic [NrFUs-1:0]    push;
  logic [NrFUs-1:0]    pop;

  logic                slot_valid_q;
  entry_t              slot_q;
  entry_t              head;
  logic [SrcWidth-1:0] src_q;
  logic [SrcWidth-1:0] rr_q;
  logic [SrcWidth-1:0] rr_d;
  logic [SrcWidth-1:0] winner;
  logic [SrcWidth-1:0] cand;
  logic                found;
  logic                load;
  logic [NrVInsn-1:0]  done_q;
  logic [NrVInsn-1:0]  done_d;

  // The slot refills whenever it is empty or its current write is accepted.
  assign load = !slot_valid_q || wb_gnt_i;

  // Per-channel unpacking and handshake; ready depends only on occupancy.
  for (genvar g = 0; g < NrFUs; g++) begin : g_ch
    assign in_entry[g]   = {fu_id_i[g*IdWidth +: IdWidth],
                            fu_addr_i[g*AddrWidth +: AddrWidth],
                            fu_wdata_i[g*DataWidth +: DataWidth],
                            fu_be_i[g*BeWidth +: BeWidth],
                            fu_last_i[g]};
    assign nonempty[g]   = (cnt_q[g] != '0);
    assign fu_ready_o[g] = (cnt_q[g] != cnt_t'(BufDepth));
    assign push[g]       = fu_valid_i[g] && fu_ready_o[g];
    assign pop[g]        = load && found && (winner == SrcWidth'(g));
  end

  // Round-robin pick: first non-empty channel at or after the pointer.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NrFUs; k++) begin
      cand = SrcWidth'((int'(rr_q) + k) % int'(NrFUs));
      if (!found && nonempty[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    rr_d = (winner == SrcWidth'(NrFUs - 1)) ? '0 : winner + SrcWidth'(1);
  end

  assign head = fifo_mem_q[winner][rptr_q[winner]];

  // Done pulse for the instruction whose last element is granted this cycle.
  always_comb begin
    done_d = '0;
    if (slot_valid_q && wb_gnt_i && slot_q.last) done_d[slot_q.id] = 1'b1;
  end

  // FIFO pointers and occupancy; simultaneous push/pop leaves the count unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrFUs; i++) begin
        cnt_q[i]  <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NrFUs; i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + PtrWidth'(1);
        if (pop[i])  rptr_q[i] <= rptr_q[i] + PtrWidth'(1);
        cnt_q[i] <= cnt_q[i] + cnt_t'(push[i]) - cnt_t'(pop[i]);
      end
    end
  end

  // FIFO storage; contents are qualified by the counters, so no reset needed.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NrFUs; i++) begin
      if (push[i]) fifo_mem_q[i][wptr_q[i]] <= in_entry[i];
    end
  end

  // Output slot, arbitration pointer and done register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_valid_q <= 1'b0;
      slot_q       <= '0;
      src_q        <= '0;
      rr_q         <= '0;
      done_q       <= '0;
    end else begin
      done_q <= done_d;
      if (load) begin
        slot_valid_q <= found;
        if (found) begin
          slot_q <= head;
          src_q  <= winner;
          rr_q   <= rr_d;
        end
      end
    end
  end

  assign wb_req_o     = slot_valid_q;
  assign wb_id_o      = slot_q.id;
  assign wb_addr_o    = slot_q.addr;
  assign wb_wdata_o   = slot_q.wdata;
  assign wb_be_o      = slot_q.be;
  assign wb_src_o     = src_q;
  assign vinsn_done_o = done_q;
  assign busy_o       = (|nonempty) | slot_valid_q;

endmodule
